// File: rtl/fc_pkg.sv
// Shared FC-stage constants, SRAM group codes and the writer FSM encoding.
// The lane/bank constants must stay in step with the FC window fetch layout.
package fc_pkg;
  localparam int DATA_WIDTH             = 8;
  localparam int DATA_NUM_PER_SRAM_ADDR = 4;
  localparam int SRAM_NUM               = 5;
  localparam int ADDR_WIDTH             = 10;
  localparam int DATA_NUM               = SRAM_NUM * DATA_NUM_PER_SRAM_ADDR;

  localparam int LANE_W = $clog2(DATA_NUM_PER_SRAM_ADDR);
  localparam int BANK_W = $clog2(SRAM_NUM);
  localparam int WEN_W  = 3 * SRAM_NUM;
  localparam int WORD_W = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH;

  typedef enum logic [1:0] {
    SRAM_C   = 2'd0,
    SRAM_D   = 2'd1,
    SRAM_E   = 2'd2,
    SRAM_INV = 2'd3
  } sram_grp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_DONE
  } fc_wr_state_e;

  // Write strobes are laid out group-major: bit g*SRAM_NUM + b.
  function automatic logic [WEN_W-1:0] wen_onehot(sram_grp_e grp, logic [BANK_W-1:0] bank);
    int idx;
    idx = int'(grp) * SRAM_NUM + int'(bank);
    return WEN_W'(1) << idx;
  endfunction
endpackage

// File: rtl/fc_sram_writer_if.sv
// Job-control, element-stream and SRAM write-port bundle of the FC write-back packer.
interface fc_sram_writer_if import fc_pkg::*; ();
  logic                  start;
  logic [1:0]            sram_sel;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic [WEN_W-1:0]      sram_wen;
  logic [ADDR_WIDTH-1:0] sram_waddr;
  logic [WORD_W-1:0]     sram_wdata;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] sram_wmask;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sram_sel, base_addr, in_valid, in_data, in_last,
    input  in_ready, sram_wen, sram_waddr, sram_wdata, sram_wmask, busy, done
  );

  modport slave (
    input  start, sram_sel, base_addr, in_valid, in_data, in_last,
    output in_ready, sram_wen, sram_waddr, sram_wdata, sram_wmask, busy, done
  );
endinterface

// File: rtl/fc_lane_packer.sv
// Gathers serial elements into one SRAM word (lane 0 in the MSBs) and reports
// the completed word, zero-padded with a lane mask, in the completing handshake cycle.
module fc_lane_packer import fc_pkg::*; (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  push,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  word_valid,
  output logic [WORD_W-1:0]     word_data,
  output logic [DATA_NUM_PER_SRAM_ADDR-1:0] word_mask
);
  localparam int LANES = DATA_NUM_PER_SRAM_ADDR;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] merged;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lane_d     = lane_q;
    pack_d     = pack_q;
    word_valid = 1'b0;
    word_data  = '0;
    word_mask  = '0;
    merged     = pack_q;
    merged[(LANES-1-int'(lane_q))*DATA_WIDTH +: DATA_WIDTH] = data;

    if (push) begin
      if (lane_q == LANE_W'(LANES-1) || last) begin
        word_valid = 1'b1;
        word_data  = merged;
        for (int i = 0; i < LANES; i++) begin
          word_mask[LANES-1-i] = (i <= int'(lane_q));
        end
        // Clearing here is what zero-pads the next partial word.
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        pack_d = merged;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end
endmodule

// File: rtl/fc_sram_writer.sv
// FC write-back packer top: job FSM plus bank/row address generation around
// fc_lane_packer; every output is registered.
module fc_sram_writer import fc_pkg::*; (
  input logic             clk,
  input logic             srstn,
  fc_sram_writer_if.slave bus
);
  fc_wr_state_e          state_q, state_d;
  sram_grp_e             group_q, group_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WEN_W-1:0]      wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] wmask_q, wmask_d;

  logic                  hs;
  logic                  word_valid;
  logic [WORD_W-1:0]     word_data;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] word_mask;

  // ready_q is high exactly while state_q is FILL, so it qualifies the handshake.
  assign hs = bus.in_valid && ready_q;

  fc_lane_packer u_packer (
    .clk        (clk),
    .srstn      (srstn),
    .push       (hs),
    .last       (bus.in_last),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_mask  (word_mask)
  );

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    row_d   = row_q;
    bank_d  = bank_q;
    wen_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && sram_grp_e'(bus.sram_sel) != SRAM_INV) begin
          state_d = ST_FILL;
          group_d = sram_grp_e'(bus.sram_sel);
          row_d   = bus.base_addr;
          bank_d  = '0;
        end
      end
      ST_FILL:  if (hs && bus.in_last) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (word_valid) begin
      wen_d   = wen_onehot(group_q, bank_q);
      waddr_d = row_q;
      wdata_d = word_data;
      wmask_d = word_mask;
      if (bank_q == BANK_W'(SRAM_NUM-1)) begin
        bank_d = '0;
        row_d  = row_q + ADDR_WIDTH'(1);
      end else begin
        bank_d = bank_q + BANK_W'(1);
      end
    end

    ready_d = (state_d == ST_FILL);
    busy_d  = (state_d == ST_FILL) || (state_d == ST_FLUSH);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
      group_q <= SRAM_C;
      row_q   <= '0;
      bank_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      row_q   <= row_d;
      bank_q  <= bank_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sram_wen   = wen_q;
  assign bus.sram_waddr = waddr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_wmask = wmask_q;
endmodule

// File: tb/tb_fc_sram_writer.sv
// Self-checking bench for fc_sram_writer: a job table plus hand-written corner
// sequences, with a write scoreboard filled at each accepted element.
module tb_fc_sram_writer;
  import fc_pkg::*;

  typedef struct packed {
    logic [14:0] wen;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  typedef struct {
    logic [1:0]  sel;
    logic [9:0]  base;
    int          n;
    logic [7:0]  v0;
    bit          gaps;
    bit          mid_start;
    int          nwr;
    int          first_bit;
    logic [9:0]  first_addr;
    logic [31:0] first_data;
    int          last_bit;
    logic [9:0]  last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_mask;
  } job_t;

  logic clk = 1'b0;
  logic srstn;
  always #5 clk = ~clk;

  fc_sram_writer_if bus ();

  fc_sram_writer dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  wr_t exp_q[$];
  wr_t act_log[$];
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;
  int  done_cnt = 0;

  // Reference model state for the job being driven.
  logic [31:0] acc_data;
  logic [3:0]  acc_mask;
  int          acc_lane;
  int          exp_bank;
  logic [9:0]  exp_row;
  int          exp_group;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.sram_wen != '0) begin
      wr_t got;
      wr_t exp;
      got = '{wen: bus.sram_wen, addr: bus.sram_waddr, data: bus.sram_wdata, mask: bus.sram_wmask};
      act_log.push_back(got);
      last_wr_cyc = cyc;
      check("wen_onehot", 64'($onehot(bus.sram_wen)), 64'd1);
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("sb_wen",  64'(got.wen),  64'(exp.wen));
        check("sb_addr", 64'(got.addr), 64'(exp.addr));
        check("sb_data", 64'(got.data), 64'(exp.data));
        check("sb_mask", 64'(got.mask), 64'(exp.mask));
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic model_accept(input logic [7:0] v, input logic last);
    acc_data[(3-acc_lane)*8 +: 8] = v;
    acc_mask[3-acc_lane] = 1'b1;
    if (acc_lane == 3 || last) begin
      exp_q.push_back('{wen: 15'(1) << (exp_group*5 + exp_bank), addr: exp_row,
                        data: acc_data, mask: acc_mask});
      acc_data = '0;
      acc_mask = '0;
      acc_lane = 0;
      if (exp_bank == 4) begin
        exp_bank = 0;
        exp_row  = exp_row + 10'd1;
      end else begin
        exp_bank++;
      end
    end else begin
      acc_lane++;
    end
  endtask

  // Entered and left at a negedge; back-to-back calls keep in_valid high across edges.
  task automatic send(input logic [7:0] v, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 64'd1, 64'd0);
    @(posedge clk);
    model_accept(v, last);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] sel, input logic [9:0] base);
    acc_data  = '0;
    acc_mask  = '0;
    acc_lane  = 0;
    exp_bank  = 0;
    exp_row   = base;
    exp_group = int'(sel);
    bus.start     = 1'b1;
    bus.sram_sel  = sel;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_job(input job_t j, input string tag);
    int g;
    act_log.delete();
    done_cnt = 0;
    start_job(j.sel, j.base);
    check({tag, "_busy_on_start"}, 64'(bus.busy), 64'd1);
    for (int i = 0; i < j.n; i++) begin
      if (j.mid_start && i == 2) begin
        bus.start     = 1'b1;
        bus.sram_sel  = 2'd2;
        bus.base_addr = 10'h055;
        @(negedge clk);
        bus.start = 1'b0;
      end
      if (j.gaps && (i % 2 == 1)) @(negedge clk);
      send(j.v0 + 8'(i), i == j.n - 1);
    end
    g = 0;
    while (done_cnt == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_num_writes"}, 64'(act_log.size()), 64'(j.nwr));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_after_last_wr"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    if (act_log.size() == j.nwr) begin
      check({tag, "_first_wen"},  64'(act_log[0].wen),  64'(15'(1) << j.first_bit));
      check({tag, "_first_addr"}, 64'(act_log[0].addr), 64'(j.first_addr));
      check({tag, "_first_data"}, 64'(act_log[0].data), 64'(j.first_data));
      check({tag, "_last_wen"},   64'(act_log[j.nwr-1].wen),  64'(15'(1) << j.last_bit));
      check({tag, "_last_addr"},  64'(act_log[j.nwr-1].addr), 64'(j.last_addr));
      check({tag, "_last_data"},  64'(act_log[j.nwr-1].data), 64'(j.last_data));
      check({tag, "_last_mask"},  64'(act_log[j.nwr-1].mask), 64'(j.last_mask));
    end
    exp_q.delete();
  endtask

  job_t jobs[6];

  initial begin
    // sel, base, n, v0, gaps, mid_start, nwr, first{bit,addr,data}, last{bit,addr,data,mask}
    jobs[0] = '{2'd0, 10'd0,    20, 8'h01, 1'b0, 1'b0, 5,  0,  10'd0,    32'h01020304,  4, 10'd0,   32'h11121314, 4'hF};
    jobs[1] = '{2'd2, 10'd5,    40, 8'h21, 1'b0, 1'b0, 10, 10, 10'd5,    32'h21222324, 14, 10'd6,   32'h45464748, 4'hF};
    jobs[2] = '{2'd1, 10'h030,  6,  8'h01, 1'b0, 1'b0, 2,  5,  10'h030,  32'h01020304,  6, 10'h030, 32'h05060000, 4'hC};
    jobs[3] = '{2'd0, 10'd1023, 40, 8'h81, 1'b0, 1'b0, 10, 0,  10'd1023, 32'h81828384,  4, 10'd0,   32'hA5A6A7A8, 4'hF};
    jobs[4] = '{2'd1, 10'd7,    8,  8'h10, 1'b1, 1'b0, 2,  5,  10'd7,    32'h10111213,  6, 10'd7,   32'h14151617, 4'hF};
    jobs[5] = '{2'd0, 10'h100,  8,  8'h31, 1'b0, 1'b1, 2,  0,  10'h100,  32'h31323334,  1, 10'h100, 32'h35363738, 4'hF};

    srstn         = 1'b0;
    bus.start     = 1'b0;
    bus.sram_sel  = 2'd0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", 64'(bus.in_ready),   64'd0);
    check("rst_busy",     64'(bus.busy),       64'd0);
    check("rst_done",     64'(bus.done),       64'd0);
    check("rst_wen",      64'(bus.sram_wen),   64'd0);
    check("rst_waddr",    64'(bus.sram_waddr), 64'd0);
    check("rst_wdata",    64'(bus.sram_wdata), 64'd0);
    check("rst_wmask",    64'(bus.sram_wmask), 64'd0);
    srstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_job(jobs[k], $sformatf("job%0d", k));
    end

    // Invalid group: the start must be ignored and nothing accepted.
    act_log.delete();
    bus.start    = 1'b1;
    bus.sram_sel = 2'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    check("sel3_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sel3_busy",   64'(bus.busy), 64'd0);
    check("sel3_writes", 64'(act_log.size()), 64'd0);

    // Reset mid-job after 7 elements: one full word written, the partial word dropped.
    act_log.delete();
    start_job(2'd1, 10'd3);
    for (int i = 0; i < 7; i++) send(8'h61 + 8'(i), 1'b0);
    srstn = 1'b0;
    @(negedge clk);
    check("abort_wen",      64'(bus.sram_wen),   64'd0);
    check("abort_busy",     64'(bus.busy),       64'd0);
    check("abort_in_ready", 64'(bus.in_ready),   64'd0);
    check("abort_waddr",    64'(bus.sram_waddr), 64'd0);
    check("abort_wdata",    64'(bus.sram_wdata), 64'd0);
    check("abort_wmask",    64'(bus.sram_wmask), 64'd0);
    @(negedge clk);
    srstn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_num_writes", 64'(act_log.size()), 64'd1);
    check("abort_sb_drained", 64'(exp_q.size()),   64'd0);
    check("abort_idle_busy",  64'(bus.busy),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
